call_latch_bank: RTL and testbench
==================================

// Module: call_latch_bank
// PURPOSE
//  Parametrised elevator call store: per-floor latches for inside-car, hall-up and hall-down calls.
//  Calls are set by encoded write requests and cleared by explicit service commands from the car controller.
//  Also produces a pending-call count and above/below summaries relative to the car's current floor.
//  Sits between the button decoders and the elevator direction/stop FSM.
// PARAMETERS
//  NUM_FLOORS  8                      number of floors, >=2; floor 0 = lowest, MSB bit = highest floor
//  FLOOR_W     $clog2(NUM_FLOORS)     width of floor index buses (derived; do not override)
//  CNT_W       $clog2(3*NUM_FLOORS+1) width of pending_cnt (derived)
//  AGE_W       8                      age counter width (used only with CALL_AGE_EN)
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  reset        in   1           asynchronous, active-low reset (0 = reset)
//  wr_valid     in   1           call request strobe, one request per cycle
//  wr_floor     in   FLOOR_W     floor of request
//  wr_type      in   2           00 inside, 01 hall-up, 10 hall-down, 11 reserved
//  svc_valid    in   1           service strobe: car stopped at svc_floor
//  svc_floor    in   FLOOR_W     floor being serviced
//  svc_dir      in   1           1 = car departing up (clear up), 0 = departing down (clear down)
//  cur_floor    in   FLOOR_W     car's current floor for summaries
//  err_clr      in   1           clears err_flag
//  call_inside  out  NUM_FLOORS  latched inside calls
//  call_up      out  NUM_FLOORS  latched hall-up calls
//  call_down    out  NUM_FLOORS  latched hall-down calls
//  pending_cnt  out  CNT_W       popcount of all three vectors, registered
//  req_above    out  1           any call at floor > cur_floor (combinational from latches)
//  req_below    out  1           any call at floor < cur_floor (combinational from latches)
//  req_here     out  1           any call at cur_floor
//  err_flag     out  1           sticky: illegal request seen
// BEHAVIOUR
//  - Reset: all call vectors 0, pending_cnt 0, err_flag 0, age counters 0; outputs valid asynchronously.
//  - Write: wr_valid in cycle N sets bit wr_floor of selected vector; visible on outputs in cycle N+1.
//    Setting an already-set bit is a no-op (no count change).
//  - Illegal writes (no state change, err_flag<=1 at N+1): wr_floor>=NUM_FLOORS; wr_type=11;
//    hall-up at floor NUM_FLOORS-1; hall-down at floor 0.
//  - Service: svc_valid in cycle N clears call_inside[svc_floor] and call_up (svc_dir=1) or
//    call_down (svc_dir=0) at svc_floor; effective N+1. svc_floor out of range: ignored, err_flag<=1.
//  - Simultaneous write and service on same floor: service clear wins for the bits it clears;
//    write to the non-cleared direction still sets. Different floors: both take effect.
//  - err_clr and a new error in the same cycle: err_flag stays 1 (set wins).
//  - pending_cnt: registered popcount of next-state vectors, so it tracks vectors with same N+1 latency;
//    max value 3*NUM_FLOORS-2 (edge-floor hall bits never set).
//  - req_above/below/here: pure combinational reduction of latched vectors vs cur_floor;
//    cur_floor>=NUM_FLOORS gives all three 0.
//  - Reset asserted mid-operation clears everything immediately; in-flight strobes are dropped.
// CONFIGURATION
//  CALL_AGE_EN defined: per-floor AGE_W-bit counter, increments each cycle while any call at that floor
//    is latched, saturates at all-ones, returns to 0 the cycle after the floor has no calls; adds outputs
//    oldest_floor (FLOOR_W) and oldest_age (AGE_W) = floor with max age, ties to lowest index; both 0 if idle.
//  CALL_AGE_EN undefined: no counters, no oldest_* ports; all other behaviour identical.
// TESTING
//  1. Reset low mid-traffic with calls latched -> all vectors 0, pending_cnt 0, err_flag 0 same cycle.
//  2. wr inside floor 5, up floor 2, down floor 7 (N=8) -> next cycle call_inside=0x20, call_up=0x04,
//     call_down=0x80, pending_cnt=3; cur_floor=3 -> req_above=1, req_below=1, req_here=0.
//  3. wr up floor 7, down floor 0, type 11 -> vectors unchanged, err_flag=1; err_clr -> err_flag=0.
//  4. Floor 4 has inside+up+down; svc floor 4 dir=1 -> only call_down[4]=1, pending_cnt 3->1.
//  5. Same cycle: svc floor 3 dir=0 and wr up floor 3 -> call_up[3]=1, call_down[3]=0, call_inside[3]=0.
//  6. CALL_AGE_EN, AGE_W=4: hold call at floor 1 for 20 cycles -> oldest_floor=1, oldest_age=15 (sat);
//     service -> age 0 next cycle, oldest_floor=0.

Source files
------------

// File: rtl/call_latch_bank_if.sv
// Call-bank bus between the button decoders / car controller and the call store.
// The oldest_* outputs exist only when CALL_AGE_EN is defined.
interface call_latch_bank_if #(
  parameter int NUM_FLOORS = 8,
  parameter int AGE_W      = 8
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int CNT_W   = $clog2(3*NUM_FLOORS+1);

  if (NUM_FLOORS < 2 || AGE_W < 1) begin : g_bad_cfg
    $error("call_latch_bank_if: NUM_FLOORS must be >= 2 and AGE_W >= 1");
  end

  logic                  wr_valid;
  logic [FLOOR_W-1:0]    wr_floor;
  logic [1:0]            wr_type;
  logic                  svc_valid;
  logic [FLOOR_W-1:0]    svc_floor;
  logic                  svc_dir;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  err_clr;
  logic [NUM_FLOORS-1:0] call_inside;
  logic [NUM_FLOORS-1:0] call_up;
  logic [NUM_FLOORS-1:0] call_down;
  logic [CNT_W-1:0]      pending_cnt;
  logic                  req_above;
  logic                  req_below;
  logic                  req_here;
  logic                  err_flag;
`ifdef CALL_AGE_EN
  logic [FLOOR_W-1:0]    oldest_floor;
  logic [AGE_W-1:0]      oldest_age;
`endif

  modport master (
    output wr_valid, wr_floor, wr_type, svc_valid, svc_floor, svc_dir, cur_floor, err_clr,
    input  call_inside, call_up, call_down, pending_cnt, req_above, req_below, req_here, err_flag
`ifdef CALL_AGE_EN
    , input oldest_floor, oldest_age
`endif
  );

  modport slave (
    input  wr_valid, wr_floor, wr_type, svc_valid, svc_floor, svc_dir, cur_floor, err_clr,
    output call_inside, call_up, call_down, pending_cnt, req_above, req_below, req_here, err_flag
`ifdef CALL_AGE_EN
    , output oldest_floor, oldest_age
`endif
  );
endinterface

// File: rtl/call_latch_bank.sv
// Per-floor elevator call latches (inside / hall-up / hall-down) with pending count and
// above/below/here summaries. Define CALL_AGE_EN for per-floor age counters and oldest_* outputs.

// One floor's three call bits; bit0 inside, bit1 up, bit2 down.
module call_floor_cell #(
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       set_v,
  input  logic [2:0]       clr_v,
  output logic [2:0]       q,
  output logic [2:0]       d
`ifdef CALL_AGE_EN
  , output logic [AGE_W-1:0] age
`endif
);
  // Service clear has priority over a same-cycle set on the same bit.
  assign d = (q | set_v) & ~clr_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

`ifdef CALL_AGE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    age <= '0;
    else if (~|d)  age <= '0;
    else if (~&age) age <= age + 1'b1;
  end
`endif
endmodule

module call_latch_bank #(
  parameter int NUM_FLOORS = 8,
  parameter int AGE_W      = 8
) (
  input logic               clk,
  input logic               reset,
  call_latch_bank_if.slave  bus
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int CNT_W   = $clog2(3*NUM_FLOORS+1);

  if (NUM_FLOORS < 2 || AGE_W < 1) begin : g_bad_cfg
    $error("call_latch_bank: NUM_FLOORS must be >= 2 and AGE_W >= 1");
  end

  logic [NUM_FLOORS-1:0][2:0] q_all, d_all;
  logic [CNT_W-1:0]           cnt_nxt, cnt_q;
  logic                       err_q;
  logic                       wr_ok, wr_err, svc_ok, svc_err, cur_ok;
  int                         wr_i, svc_i, cur_i;

  assign wr_i  = int'(bus.wr_floor);
  assign svc_i = int'(bus.svc_floor);
  assign cur_i = int'(bus.cur_floor);

  // Hall calls that point out of the shaft are rejected along with bad floors/types.
  always_comb begin
    wr_ok = bus.wr_valid && (wr_i < NUM_FLOORS) && (bus.wr_type != 2'b11)
            && !(bus.wr_type == 2'b01 && wr_i == NUM_FLOORS-1)
            && !(bus.wr_type == 2'b10 && wr_i == 0);
    wr_err  = bus.wr_valid && !wr_ok;
    svc_ok  = bus.svc_valid && (svc_i < NUM_FLOORS);
    svc_err = bus.svc_valid && !svc_ok;
    cur_ok  = cur_i < NUM_FLOORS;
  end

`ifdef CALL_AGE_EN
  logic [NUM_FLOORS-1:0][AGE_W-1:0] age_all;
`endif

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    logic       hit_wr, hit_svc;
    logic [2:0] set_v, clr_v;
    assign hit_wr  = wr_ok && (wr_i == f);
    assign hit_svc = svc_ok && (svc_i == f);
    assign set_v   = {hit_wr && bus.wr_type == 2'b10,
                      hit_wr && bus.wr_type == 2'b01,
                      hit_wr && bus.wr_type == 2'b00};
    assign clr_v   = {hit_svc && !bus.svc_dir, hit_svc && bus.svc_dir, hit_svc};

    call_floor_cell #(.AGE_W(AGE_W)) u_cell (
      .clk   (clk),
      .reset (reset),
      .set_v (set_v),
      .clr_v (clr_v),
      .q     (q_all[f]),
      .d     (d_all[f])
`ifdef CALL_AGE_EN
      , .age (age_all[f])
`endif
    );

    assign bus.call_inside[f] = q_all[f][0];
    assign bus.call_up[f]     = q_all[f][1];
    assign bus.call_down[f]   = q_all[f][2];
  end

  // Count is taken from next-state so it lands on the same edge as the vectors.
  always_comb begin
    cnt_nxt = '0;
    for (int f = 0; f < NUM_FLOORS; f++)
      cnt_nxt = cnt_nxt + CNT_W'(d_all[f][0]) + CNT_W'(d_all[f][1]) + CNT_W'(d_all[f][2]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (wr_err || svc_err) err_q <= 1'b1;
      else if (bus.err_clr)  err_q <= 1'b0;
    end
  end

  assign bus.pending_cnt = cnt_q;
  assign bus.err_flag    = err_q;

  always_comb begin
    bus.req_above = 1'b0;
    bus.req_below = 1'b0;
    bus.req_here  = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (cur_ok && f > cur_i)  bus.req_above = bus.req_above | (|q_all[f]);
      if (cur_ok && f < cur_i)  bus.req_below = bus.req_below | (|q_all[f]);
      if (cur_ok && f == cur_i) bus.req_here  = bus.req_here  | (|q_all[f]);
    end
  end

`ifdef CALL_AGE_EN
  // Strict '>' keeps the lowest floor on ties; idle bank yields floor 0, age 0.
  always_comb begin
    bus.oldest_floor = '0;
    bus.oldest_age   = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (age_all[f] > bus.oldest_age) begin
        bus.oldest_age   = age_all[f];
        bus.oldest_floor = FLOOR_W'(f);
      end
    end
  end
`endif
endmodule

// File: tb/tb_call_latch_bank.sv
// Directed bench for call_latch_bank (NUM_FLOORS=8, AGE_W=4); age checks run when CALL_AGE_EN is defined.
module tb_call_latch_bank;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  call_latch_bank_if #(.NUM_FLOORS(8), .AGE_W(4)) bus ();
  call_latch_bank #(.NUM_FLOORS(8), .AGE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] f, input logic [1:0] t);
    bus.wr_valid = 1'b1; bus.wr_floor = f; bus.wr_type = t;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic svc(input logic [2:0] f, input logic dir);
    bus.svc_valid = 1'b1; bus.svc_floor = f; bus.svc_dir = dir;
    tick();
    bus.svc_valid = 1'b0;
  endtask

  task automatic chk_vec(input string tag, input logic [7:0] ei, input logic [7:0] eu,
                         input logic [7:0] ed, input logic [4:0] ec);
    chk({tag, ".inside"}, 32'(bus.call_inside), 32'(ei));
    chk({tag, ".up"},     32'(bus.call_up),     32'(eu));
    chk({tag, ".down"},   32'(bus.call_down),   32'(ed));
    chk({tag, ".cnt"},    32'(bus.pending_cnt), 32'(ec));
  endtask

  task automatic chk_sum(input string tag, input logic [2:0] cf, input logic a,
                         input logic b, input logic h);
    bus.cur_floor = cf;
    #1;
    chk({tag, ".above"}, 32'(bus.req_above), 32'(a));
    chk({tag, ".below"}, 32'(bus.req_below), 32'(b));
    chk({tag, ".here"},  32'(bus.req_here),  32'(h));
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_floor = '0; bus.wr_type = '0;
    bus.svc_valid = 1'b0; bus.svc_floor = '0; bus.svc_dir = 1'b0;
    bus.cur_floor = '0; bus.err_clr = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk_vec("reset", 8'h00, 8'h00, 8'h00, 5'd0);
    chk("reset.err", 32'(bus.err_flag), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // basic writes and summaries
    wr(3'd5, 2'b00);
    chk_vec("wr_in5", 8'h20, 8'h00, 8'h00, 5'd1);
    wr(3'd2, 2'b01);
    wr(3'd7, 2'b10);
    chk_vec("wr3", 8'h20, 8'h04, 8'h80, 5'd3);
    chk_sum("cur3", 3'd3, 1'b1, 1'b1, 1'b0);
    chk_sum("cur5", 3'd5, 1'b1, 1'b1, 1'b1);
    chk_sum("cur0", 3'd0, 1'b1, 1'b0, 1'b0);
    chk_sum("cur7", 3'd7, 1'b0, 1'b1, 1'b1);
    wr(3'd5, 2'b00);
    chk_vec("dup", 8'h20, 8'h04, 8'h80, 5'd3);
    chk("dup.err", 32'(bus.err_flag), 32'd0);

    // illegal writes
    wr(3'd7, 2'b01);
    chk_vec("ill_up7", 8'h20, 8'h04, 8'h80, 5'd3);
    chk("ill_up7.err", 32'(bus.err_flag), 32'd1);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("errclr1", 32'(bus.err_flag), 32'd0);
    wr(3'd0, 2'b10);
    chk("ill_dn0.err", 32'(bus.err_flag), 32'd1);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("errclr2", 32'(bus.err_flag), 32'd0);
    bus.err_clr = 1'b1;
    wr(3'd3, 2'b11);
    bus.err_clr = 1'b0;
    chk_vec("ill_t3", 8'h20, 8'h04, 8'h80, 5'd3);
    chk("set_wins.err", 32'(bus.err_flag), 32'd1);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("errclr3", 32'(bus.err_flag), 32'd0);

    // service at floor 4 departing up
    wr(3'd4, 2'b00); wr(3'd4, 2'b01); wr(3'd4, 2'b10);
    chk_vec("fl4_all", 8'h30, 8'h14, 8'h90, 5'd6);
    svc(3'd4, 1'b1);
    chk_vec("svc4_up", 8'h20, 8'h04, 8'h90, 5'd4);

    // same-floor service and write
    wr(3'd3, 2'b00); wr(3'd3, 2'b10);
    chk_vec("fl3_pre", 8'h28, 8'h04, 8'h98, 5'd6);
    bus.wr_valid = 1'b1; bus.wr_floor = 3'd3; bus.wr_type = 2'b01;
    svc(3'd3, 1'b0);
    bus.wr_valid = 1'b0;
    chk_vec("same_fl", 8'h20, 8'h0C, 8'h90, 5'd5);

    // different-floor service and write
    bus.wr_valid = 1'b1; bus.wr_floor = 3'd6; bus.wr_type = 2'b00;
    svc(3'd5, 1'b1);
    bus.wr_valid = 1'b0;
    chk_vec("diff_fl", 8'h40, 8'h0C, 8'h90, 5'd5);
    chk_sum("cur4", 3'd4, 1'b1, 1'b1, 1'b1);

    // reset mid-traffic with an error latched and a strobe in flight
    wr(3'd2, 2'b11);
    chk("pre_rst.err", 32'(bus.err_flag), 32'd1);
    bus.wr_valid = 1'b1; bus.wr_floor = 3'd1; bus.wr_type = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk_vec("midrst", 8'h00, 8'h00, 8'h00, 5'd0);
    chk("midrst.err", 32'(bus.err_flag), 32'd0);
    chk_sum("midrst", 3'd4, 1'b0, 1'b0, 1'b0);
    tick();
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk_vec("post_rst", 8'h00, 8'h00, 8'h00, 5'd0);

`ifdef CALL_AGE_EN
    chk("age_idle.floor", 32'(bus.oldest_floor), 32'd0);
    chk("age_idle.age",   32'(bus.oldest_age),   32'd0);
    wr(3'd1, 2'b00);
    chk("age_first", 32'(bus.oldest_age), 32'd1);
    for (int i = 0; i < 19; i++) tick();
    chk("age_sat.floor", 32'(bus.oldest_floor), 32'd1);
    chk("age_sat.age",   32'(bus.oldest_age),   32'd15);
    svc(3'd1, 1'b1);
    chk("age_clr.floor", 32'(bus.oldest_floor), 32'd0);
    chk("age_clr.age",   32'(bus.oldest_age),   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
